// File: rtl/mtimer_pkg.sv
// Register map of the machine timer window and a byte-lane write merge helper.
package mtimer_pkg;

  localparam logic [4:0] REG_MTIME_LO    = 5'h00;
  localparam logic [4:0] REG_MTIME_HI    = 5'h04;
  localparam logic [4:0] REG_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] REG_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] REG_CTRL        = 5'h10;
  localparam logic [4:0] REG_PRESCALE    = 5'h14;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcode constants and the two-state slave response FSM encoding.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ARITHMETIC      = 3'd2;
  localparam logic [2:0] LOGICAL         = 3'd3;
  localparam logic [2:0] GET             = 3'd4;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } tl_state_e;

endpackage

// File: rtl/mtimer_tick_gen.sv
// Prescaler for mtime: one tick every (prescale + 1) enabled cycles; frozen while en=0.
module mtimer_tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  // >= rather than == so a reload lowered below the running count recovers at once.
  assign tick = en && (count >= prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tl_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) as a single-outstanding TileLink-UL slave.
// Define MTIMER_ATOMIC_READ_EN to make MTIME_HI return the value snapshotted by the last MTIME_LO read.
module tl_mtimer #(
  parameter int                    SOURCE_W     = 1,
  parameter int                    PRESCALE_W   = 16,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          tl_a_opcode,
  input  logic [2:0]          tl_a_param,
  input  logic [3:0]          tl_a_size,
  input  logic [SOURCE_W-1:0] tl_a_source,
  input  logic [4:0]          tl_a_address,
  input  logic [3:0]          tl_a_mask,
  input  logic [31:0]         tl_a_data,
  input  logic                tl_a_corrupt,
  input  logic                tl_a_valid,
  output logic                tl_a_ready,
  output logic [2:0]          tl_d_opcode,
  output logic [1:0]          tl_d_param,
  output logic [3:0]          tl_d_size,
  output logic [SOURCE_W-1:0] tl_d_source,
  output logic                tl_d_denied,
  output logic [31:0]         tl_d_data,
  output logic                tl_d_corrupt,
  output logic                tl_d_valid,
  input  logic                tl_d_ready,
  output logic                timer_irq
);
  import tl_ul_pkg::*;
  import mtimer_pkg::*;

  // Handshake: a beat moves on a channel at a rising edge where valid && ready;
  // D fields are registered at A acceptance and held until the D handshake.
  tl_state_e state_q, state_d;

  logic [63:0]           mtime_q, mtime_d, mtimecmp_q;
  logic                  en_q, irq_q, tick;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           prescale_ext, prescale_merged, mtime_hi_rd, rd_word;
  logic [4:0]            reg_addr;
  logic                  accept, is_get, is_put, is_data_op, req_err, wr_en, rd_en;
  logic                  unused_ok;

  assign accept       = tl_a_valid && tl_a_ready;
  assign reg_addr     = {tl_a_address[4:2], 2'b00};
  assign is_get       = (tl_a_opcode == GET);
  assign is_put       = (tl_a_opcode == PUT_FULL) || (tl_a_opcode == PUT_PARTIAL);
  assign is_data_op   = is_get || (tl_a_opcode == ARITHMETIC) || (tl_a_opcode == LOGICAL);
  assign req_err      = !(is_get || is_put) || (tl_a_size > 4'd2);
  assign wr_en        = accept && is_put && !req_err;
  assign rd_en        = accept && is_get && !req_err;
  assign prescale_ext = 32'(prescale_q);
  assign prescale_merged = lane_merge(prescale_ext, tl_a_data, tl_a_mask);
  assign unused_ok    = ^{tl_a_param, tl_a_corrupt, tl_a_address[1:0], prescale_merged};

  assign tl_a_ready   = (state_q == ST_IDLE) && !rst;
  assign tl_d_valid   = (state_q == ST_RESP);
  assign tl_d_param   = 2'b00;
  assign tl_d_corrupt = 1'b0;
  assign timer_irq    = irq_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_RESP;
      ST_RESP: if (tl_d_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  mtimer_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (en_q),
    .prescale (prescale_q),
    .tick     (tick)
  );

`ifdef MTIMER_ATOMIC_READ_EN
  logic [31:0] shadow_q;
  always_ff @(posedge clk) begin
    if (rst)                                     shadow_q <= '0;
    else if (rd_en && reg_addr == REG_MTIME_LO)  shadow_q <= mtime_q[63:32];
  end
  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    rd_word = '0;
    case (reg_addr)
      REG_MTIME_LO:    rd_word = mtime_q[31:0];
      REG_MTIME_HI:    rd_word = mtime_hi_rd;
      REG_MTIMECMP_LO: rd_word = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: rd_word = mtimecmp_q[63:32];
      REG_CTRL:        rd_word = {30'd0, irq_q, en_q};
      REG_PRESCALE:    rd_word = prescale_ext;
      default:         rd_word = '0;
    endcase
  end

  // A software write to either half overrides a coincident tick without carrying.
  always_comb begin
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr_en && reg_addr == REG_MTIME_LO)
      mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], tl_a_data, tl_a_mask)};
    if (wr_en && reg_addr == REG_MTIME_HI)
      mtime_d = {lane_merge(mtime_q[63:32], tl_a_data, tl_a_mask), mtime_q[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      en_q        <= 1'b0;
      prescale_q  <= PRESCALE_RST;
      irq_q       <= 1'b0;
      tl_d_opcode <= '0;
      tl_d_size   <= '0;
      tl_d_source <= '0;
      tl_d_denied <= 1'b0;
      tl_d_data   <= '0;
    end else begin
      mtime_q <= mtime_d;
      irq_q   <= (mtime_q >= mtimecmp_q);
      if (wr_en && reg_addr == REG_MTIMECMP_LO)
        mtimecmp_q[31:0] <= lane_merge(mtimecmp_q[31:0], tl_a_data, tl_a_mask);
      if (wr_en && reg_addr == REG_MTIMECMP_HI)
        mtimecmp_q[63:32] <= lane_merge(mtimecmp_q[63:32], tl_a_data, tl_a_mask);
      if (wr_en && reg_addr == REG_CTRL && tl_a_mask[0])
        en_q <= tl_a_data[0];
      if (wr_en && reg_addr == REG_PRESCALE)
        prescale_q <= prescale_merged[PRESCALE_W-1:0];
      if (accept) begin
        tl_d_opcode <= is_data_op ? ACCESS_ACK_DATA : ACCESS_ACK;
        tl_d_size   <= tl_a_size;
        tl_d_source <= tl_a_source;
        tl_d_denied <= req_err;
        tl_d_data   <= rd_en ? rd_word : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_tl_mtimer.sv
// Directed bench for tl_mtimer: register map, counter/prescaler timing, irq, errors, stalls, reset.
module tb_tl_mtimer;
  import tl_ul_pkg::*;
  import mtimer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  tl_a_opcode, tl_a_param;
  logic [3:0]  tl_a_size, tl_a_mask;
  logic [0:0]  tl_a_source;
  logic [4:0]  tl_a_address;
  logic [31:0] tl_a_data;
  logic        tl_a_corrupt, tl_a_valid, tl_a_ready;
  logic [2:0]  tl_d_opcode;
  logic [1:0]  tl_d_param;
  logic [3:0]  tl_d_size;
  logic [0:0]  tl_d_source;
  logic        tl_d_denied, tl_d_corrupt, tl_d_valid, tl_d_ready;
  logic [31:0] tl_d_data;
  logic        timer_irq;

  tl_mtimer dut (
    .clk(clk), .rst(rst),
    .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size),
    .tl_a_source(tl_a_source), .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask),
    .tl_a_data(tl_a_data), .tl_a_corrupt(tl_a_corrupt), .tl_a_valid(tl_a_valid),
    .tl_a_ready(tl_a_ready), .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param),
    .tl_d_size(tl_d_size), .tl_d_source(tl_d_source), .tl_d_denied(tl_d_denied),
    .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt), .tl_d_valid(tl_d_valid),
    .tl_d_ready(tl_d_ready), .timer_irq(timer_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cyc  = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mtime seen by a read accepted at edge r, counting from enable at edge e with reload p.
  function automatic logic [63:0] mt_at(input logic [63:0] m0, input int e, input int p, input int r);
    if (r - 1 < e) return m0;
    return m0 + 64'((r - 1 - e) / (p + 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tl_a_valid = 1'b0; tl_d_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_a_ready", 64'(tl_a_ready), 64'd0);
    check_eq("rst_d_valid", 64'(tl_d_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // driver: one A beat, D sampled the cycle after acceptance, D accepted with d_ready=1
  task automatic xfer(input logic [2:0] op, input logic [4:0] addr, input logic [3:0] size,
                      input logic [3:0] mask, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic [2:0] dop, output logic dden);
    int waits;
    waits = 0; rdata = '0; dop = '0; dden = 1'b0;
    while (tl_a_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (tl_a_ready !== 1'b1) begin
      check_eq("a_ready_wait", 64'(tl_a_ready), 64'd1);
      return;
    end
    tl_a_opcode = op; tl_a_address = addr; tl_a_size = size;
    tl_a_mask = mask; tl_a_data = wdata; tl_a_source = 1'b0; tl_a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tl_a_valid = 1'b0;
    acc_cyc = cyc;
    check_eq("d_valid_next", 64'(tl_d_valid), 64'd1);
    rdata = tl_d_data; dop = tl_d_opcode; dden = tl_d_denied;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] d);
    logic [31:0] r; logic [2:0] o; logic e;
    xfer(PUT_FULL, addr, 4'd2, 4'hF, d, r, o, e);
  endtask

  task automatic rd(input logic [4:0] addr, output logic [31:0] d);
    logic [2:0] o; logic e;
    xfer(GET, addr, 4'd2, 4'h0, 32'd0, d, o, e);
  endtask

  initial begin
    logic [31:0] r, hi_snap;
    logic [2:0]  o;
    logic        den;
    logic [63:0] m;
    int          e, d, r1, r2, rise;

    rst = 1'b1; tl_a_opcode = '0; tl_a_param = '0; tl_a_size = '0; tl_a_source = '0;
    tl_a_address = '0; tl_a_mask = '0; tl_a_data = '0; tl_a_corrupt = 1'b0;
    tl_a_valid = 1'b0; tl_d_ready = 1'b1;

    // reset values
    do_reset();
    check_eq("a_ready_after_rst", 64'(tl_a_ready), 64'd1);
    check_eq("irq_rst", 64'(timer_irq), 64'd0);
    xfer(GET, REG_MTIME_LO, 4'd2, 4'h0, 32'd0, r, o, den);
    check_eq("mtime_lo_rst", 64'(r), 64'd0);
    check_eq("get_opcode", 64'(o), 64'(ACCESS_ACK_DATA));
    check_eq("get_denied", 64'(den), 64'd0);
    xfer(GET, REG_MTIMECMP_LO, 4'd2, 4'h0, 32'd0, r, o, den);
    check_eq("mtimecmp_lo_rst", 64'(r), 64'hFFFF_FFFF);
    rd(REG_CTRL, r);     check_eq("ctrl_rst", 64'(r), 64'd0);
    rd(REG_PRESCALE, r); check_eq("prescale_rst", 64'(r), 64'd0);

    // PRESCALE=0 counting and irq timing
    wr(REG_PRESCALE, 32'd0);
    wr(REG_MTIMECMP_LO, 32'd10);
    wr(REG_MTIMECMP_HI, 32'd0);
    wr(REG_CTRL, 32'd1);
    e = acc_cyc;
    for (int i = 0; i < 3; i++) begin
      rd(REG_MTIME_LO, r);
      m = mt_at(64'd0, e, 0, acc_cyc);
      check_eq("mtime_run_p0", 64'(r), 64'(m[31:0]));
    end
    check_eq("irq_early", 64'(timer_irq), 64'd0);
    rise = -1;
    for (int i = 0; i < 30 && rise < 0; i++) begin
      @(negedge clk);
      if (timer_irq === 1'b1) rise = cyc;
    end
    check_eq("irq_rise_cycle", 64'(rise), 64'(e + 11));
    rd(REG_CTRL, r); check_eq("ctrl_pending", 64'(r), 64'd3);
    wr(REG_CTRL, 32'd0);
    d = acc_cyc;
    rd(REG_MTIME_LO, r); check_eq("mtime_stop_p0", 64'(r), 64'(d - e));
    check_eq("irq_indep_en", 64'(timer_irq), 64'd1);

    // carry from LO into HI
    do_reset();
    wr(REG_PRESCALE, 32'd1);
    wr(REG_MTIME_LO, 32'hFFFF_FFFF);
    wr(REG_MTIME_HI, 32'd0);
    wr(REG_CTRL, 32'd1);
    e = acc_cyc;
    wr(REG_CTRL, 32'd0);
    d = acc_cyc;
    m = 64'hFFFF_FFFF + 64'((d - e) / 2);
    rd(REG_MTIME_LO, r); check_eq("carry_lo", 64'(r), 64'(m[31:0]));
    rd(REG_MTIME_HI, r); check_eq("carry_hi", 64'(r), 64'(m[63:32]));

    // LO read, carry, then HI read
    wr(REG_MTIME_LO, 32'hFFFF_FFFF);
    wr(REG_MTIME_HI, 32'd0);
    wr(REG_CTRL, 32'd1);
    e = acc_cyc;
    rd(REG_MTIME_LO, r);
    r1 = acc_cyc;
    m = mt_at(64'hFFFF_FFFF, e, 1, r1);
    hi_snap = m[63:32];
    check_eq("atomic_lo", 64'(r), 64'(m[31:0]));
    rd(REG_MTIME_HI, r);
    r2 = acc_cyc;
    m = mt_at(64'hFFFF_FFFF, e, 1, r2);
`ifdef MTIMER_ATOMIC_READ_EN
    check_eq("atomic_hi", 64'(r), 64'(hi_snap));
`else
    check_eq("live_hi", 64'(r), 64'(m[63:32]));
`endif
    wr(REG_CTRL, 32'd0);

    // PRESCALE=3 for ~40 cycles, then frozen
    do_reset();
    wr(REG_PRESCALE, 32'd3);
    wr(REG_CTRL, 32'd1);
    e = acc_cyc;
    repeat (40) @(negedge clk);
    wr(REG_CTRL, 32'd0);
    d = acc_cyc;
    rd(REG_MTIME_LO, r); check_eq("mtime_p3", 64'(r), 64'((d - e) / 4));
    rd(REG_MTIME_HI, r); check_eq("mtime_hi_p3", 64'(r), 64'd0);
    repeat (10) @(negedge clk);
    rd(REG_MTIME_LO, r); check_eq("mtime_frozen", 64'(r), 64'((d - e) / 4));
    rd(REG_PRESCALE, r); check_eq("prescale_rd", 64'(r), 64'd3);

    // partial writes and error responses
    wr(REG_MTIMECMP_LO, 32'h1234_5678);
    xfer(PUT_PARTIAL, REG_MTIMECMP_LO, 4'd2, 4'b0010, 32'h0000_AB00, r, o, den);
    check_eq("partial_opcode", 64'(o), 64'(ACCESS_ACK));
    check_eq("partial_denied", 64'(den), 64'd0);
    rd(REG_MTIMECMP_LO, r); check_eq("partial_lane", 64'(r), 64'h1234_AB78);
    rd(REG_MTIMECMP_HI, r); check_eq("cmp_hi_keep", 64'(r), 64'hFFFF_FFFF);
    xfer(ARITHMETIC, REG_MTIMECMP_LO, 4'd2, 4'hF, 32'd0, r, o, den);
    check_eq("arith_denied", 64'(den), 64'd1);
    check_eq("arith_data", 64'(r), 64'd0);
    xfer(GET, REG_MTIMECMP_LO, 4'd3, 4'hF, 32'd0, r, o, den);
    check_eq("get8_denied", 64'(den), 64'd1);
    check_eq("get8_opcode", 64'(o), 64'(ACCESS_ACK_DATA));
    check_eq("get8_data", 64'(r), 64'd0);
    xfer(PUT_FULL, REG_MTIMECMP_LO, 4'd3, 4'hF, 32'd0, r, o, den);
    check_eq("put8_denied", 64'(den), 64'd1);
    check_eq("put8_opcode", 64'(o), 64'(ACCESS_ACK));
    rd(REG_MTIMECMP_LO, r); check_eq("err_no_effect", 64'(r), 64'h1234_AB78);
    xfer(PUT_FULL, 5'h18, 4'd2, 4'hF, 32'hDEAD_BEEF, r, o, den);
    check_eq("rsvd_wr_denied", 64'(den), 64'd0);
    xfer(GET, 5'h18, 4'd2, 4'hF, 32'd0, r, o, den);
    check_eq("rsvd_rd_data", 64'(r), 64'd0);
    check_eq("rsvd_rd_denied", 64'(den), 64'd0);

    // D back-pressure with a competing A request
    tl_d_ready = 1'b0;
    tl_a_opcode = GET; tl_a_address = REG_MTIMECMP_LO; tl_a_size = 4'd2;
    tl_a_mask = 4'hF; tl_a_data = 32'd0; tl_a_source = 1'b1; tl_a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tl_a_opcode = PUT_FULL; tl_a_source = 1'b0; tl_a_data = 32'd0;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_d_valid", 64'(tl_d_valid), 64'd1);
      check_eq("stall_a_ready", 64'(tl_a_ready), 64'd0);
      check_eq("stall_d_data", 64'(tl_d_data), 64'h1234_AB78);
      check_eq("stall_d_source", 64'(tl_d_source), 64'd1);
      check_eq("stall_d_size", 64'(tl_d_size), 64'd2);
      @(negedge clk);
    end
    tl_a_valid = 1'b0;
    tl_d_ready = 1'b1;
    @(negedge clk);
    check_eq("stall_release", 64'(tl_d_valid), 64'd0);
    rd(REG_MTIMECMP_LO, r); check_eq("no_accept_in_resp", 64'(r), 64'h1234_AB78);

    // reset while a response is pending
    tl_d_ready = 1'b0;
    tl_a_opcode = GET; tl_a_address = REG_MTIMECMP_LO; tl_a_size = 4'd2;
    tl_a_mask = 4'hF; tl_a_source = 1'b1; tl_a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tl_a_valid = 1'b0;
    check_eq("pre_rst_d_valid", 64'(tl_d_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_drop_d_valid", 64'(tl_d_valid), 64'd0);
    check_eq("rst_drop_d_data", 64'(tl_d_data), 64'd0);
    check_eq("rst_drop_d_source", 64'(tl_d_source), 64'd0);
    check_eq("rst_drop_a_ready", 64'(tl_a_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_stale_d", 64'(tl_d_valid), 64'd0);
    end
    check_eq("ready_after_rst", 64'(tl_a_ready), 64'd1);
    tl_d_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
